// File: rtl/hilo_ctrl_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide sequencer.
package hilo_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic {
        HL_IDLE = 1'b0,
        HL_RUN  = 1'b1
    } hl_state_t;

    localparam int DEF_MUL_CYCLES = 4;
    localparam int DEF_DIV_CYCLES = 32;

    // True for the two divide opcodes.
    function automatic logic is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/hilo_ctrl_mul_div.sv
// Combinational multiply/divide datapath. l32 is the low product or the
// quotient, h32 is the high product or the remainder. Signed division is done
// on magnitudes so the most-negative dividend never overflows.
module mul_div
    import hilo_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic [31:0] l32,
    output logic [31:0] h32
);

    logic        sgn_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [63:0] prod_s;

    // Operand sign handling and the raw unsigned multiply/divide.
    always_comb begin
        sgn_s   = (op == MD_MULT) || (op == MD_DIV);
        a_neg_s = sgn_s & a[31];
        b_neg_s = sgn_s & b[31];
        a_mag_s = a_neg_s ? (32'd0 - a) : a;
        b_mag_s = b_neg_s ? (32'd0 - b) : b;
        prod_s  = {{32{a_neg_s}}, a} * {{32{b_neg_s}}, b};
        if (b_mag_s == 32'd0) begin
            // Divide by zero is flagged by the sequencer; keep the datapath defined.
            q_mag_s = 32'd0;
            r_mag_s = 32'd0;
        end else begin
            q_mag_s = a_mag_s / b_mag_s;
            r_mag_s = a_mag_s % b_mag_s;
        end
    end

    // Result selection: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        l32 = 32'd0;
        h32 = 32'd0;
        case (op)
            MD_MULT, MD_MULTU: begin
                l32 = prod_s[31:0];
                h32 = prod_s[63:32];
            end
            MD_DIV: begin
                l32 = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
                h32 = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
            end
            MD_DIVU: begin
                l32 = q_mag_s;
                h32 = r_mag_s;
            end
            default: begin
                l32 = 32'd0;
                h32 = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO owner and fixed-latency sequencer for the multiply/divide unit.
// Operands are latched at issue so mul_div sees stable inputs; the result is
// sampled only on the completion edge. Moves to HI/LO cancel any operation.
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] da,
    input  logic [31:0] db,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfhi,
    input  logic        mflo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        ready,
    output logic        stall,
    output logic        dz
);

    localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    hl_state_t   state_r;
    hl_state_t   state_nx_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_nx_s;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [1:0]  op_r;
    logic        dzf_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        accept_s;
    logic        commit_s;
    logic        dz_s;
    logic        ready_s;
    logic [31:0] l32_s;
    logic [31:0] h32_s;

    mul_div u_mul_div (
        .a   (a_r),
        .b   (b_r),
        .op  (op_r),
        .l32 (l32_s),
        .h32 (h32_s)
    );

    // Next-state, counter and completion decisions.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        accept_s   = 1'b0;
        commit_s   = 1'b0;
        dz_s       = 1'b0;
        ready_s    = (state_r == HL_IDLE) && !mthi && !mtlo;
        case (state_r)
            HL_IDLE: begin
                if (start && ready_s) begin
                    state_nx_s = HL_RUN;
                    accept_s   = 1'b1;
                    cnt_nx_s   = is_div(op) ? DIV_LOAD : MUL_LOAD;
                end else begin
                    state_nx_s = HL_IDLE;
                end
            end
            HL_RUN: begin
                if (mthi || mtlo) begin
                    // A move abandons the in-flight operation silently.
                    state_nx_s = HL_IDLE;
                    cnt_nx_s   = 8'd0;
                end else if (cnt_r == 8'd0) begin
                    state_nx_s = HL_IDLE;
                    if (dzf_r) begin
                        dz_s = 1'b1;
                    end else begin
                        commit_s = 1'b1;
                    end
                end else begin
                    cnt_nx_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_nx_s = HL_IDLE;
                cnt_nx_s   = 8'd0;
            end
        endcase
    end

    // State, counter and operand capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= HL_IDLE;
            cnt_r   <= 8'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            op_r    <= 2'd0;
            dzf_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if (accept_s) begin
                a_r   <= da;
                b_r   <= db;
                op_r  <= op;
                dzf_r <= is_div(op) && (db == 32'd0);
            end
        end
    end

    // Architectural HI/LO: moves take priority over a result commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else begin
            if (mthi) begin
                hi_r <= da;
            end else if (commit_s) begin
                hi_r <= h32_s;
            end
            if (mtlo) begin
                lo_r <= da;
            end else if (commit_s) begin
                lo_r <= l32_s;
            end
        end
    end

    assign hi    = hi_r;
    assign lo    = lo_r;
    assign busy  = (state_r == HL_RUN);
    assign ready = ready_s;
    assign stall = busy && (start || mfhi || mflo);
    assign dz    = dz_s && !rst;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with hand-computed expectations.
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] da;
    logic [31:0] db;
    logic        mthi;
    logic        mtlo;
    logic        mfhi;
    logic        mflo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        ready;
    logic        stall;
    logic        dz;

    int tests = 0;
    int fails = 0;
    int nb;
    int ns;
    int nd;

    hilo_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .da    (da),
        .db    (db),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .mfhi  (mfhi),
        .mflo  (mflo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .ready (ready),
        .stall (stall),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation and count its busy cycles (bounded).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        start = 1'b1; op = o; da = a; db = b;
        tick();
        start = 1'b0;
        cycles = 0;
        for (int i = 0; i < 300 && busy === 1'b1; i++) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'd0; da = 32'd0; db = 32'd0;
        mthi = 1'b0; mtlo = 1'b0; mfhi = 1'b0; mflo = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);

        // MULT -2*3; mfhi arrives in the second busy cycle and stalls 3 cycles.
        start = 1'b1; op = 2'd0; da = 32'hFFFFFFFE; db = 32'd3;
        #1;
        chk("mult_ready", {31'd0, ready}, 32'd1);
        chk("mult_stall_idle", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        nb = 0; ns = 0;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            if (i == 1) mfhi = 1'b1;
            #1;
            if (stall === 1'b1) ns++;
            nb++;
            tick();
        end
        chk("mult_busy_cycles", nb, 32'd4);
        chk("mult_mfhi_stalls", ns, 32'd3);
        chk("mult_stall_after", {31'd0, stall}, 32'd0);
        mfhi = 1'b0;
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        // DIVU 7/2
        run_op(2'd3, 32'd7, 32'd2, nb);
        chk("divu_busy_cycles", nb, 32'd32);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        // DIV -7/2 -> q=-3, r=-1
        run_op(2'd2, 32'hFFFFFFF9, 32'd2, nb);
        chk("div_busy_cycles", nb, 32'd32);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        // DIV most-negative / -1 wraps to itself, remainder 0
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, nb);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'd0);

        // MULTU max*max
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
        chk("multu_busy_cycles", nb, 32'd4);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        // MTHI+MTLO together, then MTLO alone
        mthi = 1'b1; mtlo = 1'b1; da = 32'h11;
        #1;
        chk("mt_ready_low", {31'd0, ready}, 32'd0);
        tick();
        mthi = 1'b0; da = 32'h22;
        tick();
        mtlo = 1'b0;
        chk("mt_hi", hi, 32'h11);
        chk("mt_lo", lo, 32'h22);

        // DIVU by zero: dz pulses once, HI/LO untouched
        start = 1'b1; op = 2'd3; da = 32'd9; db = 32'd0;
        tick();
        start = 1'b0;
        nb = 0; nd = 0;
        for (int i = 0; i < 300 && busy === 1'b1; i++) begin
            if (dz === 1'b1) nd++;
            nb++;
            tick();
        end
        if (dz === 1'b1) nd++;
        tick();
        if (dz === 1'b1) nd++;
        chk("dz_busy_cycles", nb, 32'd32);
        chk("dz_pulses", nd, 32'd1);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);

        // MTLO in the second busy cycle of a MULT cancels it
        start = 1'b1; op = 2'd0; da = 32'd7; db = 32'd9;
        tick();
        start = 1'b0;
        tick();
        mtlo = 1'b1; da = 32'd5;
        #1;
        chk("cancel_ready_low", {31'd0, ready}, 32'd0);
        tick();
        mtlo = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_lo", lo, 32'd5);
        chk("cancel_hi", hi, 32'h11);
        for (int i = 0; i < 6; i++) tick();
        chk("cancel_no_commit_lo", lo, 32'd5);
        chk("cancel_no_commit_hi", hi, 32'h11);

        // start with mthi: the move wins, start is not accepted
        start = 1'b1; mthi = 1'b1; op = 2'd1; da = 32'h33; db = 32'd2;
        tick();
        start = 1'b0; mthi = 1'b0;
        chk("move_wins_busy", {31'd0, busy}, 32'd0);
        chk("move_wins_hi", hi, 32'h33);

        // Back-to-back MULTU with start held
        start = 1'b1; op = 2'd1; da = 32'd3; db = 32'd5;
        tick();
        da = 32'd4; db = 32'd6;
        nb = 0; ns = 0;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            #1;
            if (stall === 1'b1) ns++;
            nb++;
            tick();
        end
        chk("b2b_first_busy", nb, 32'd4);
        chk("b2b_stalls", ns, 32'd4);
        chk("b2b_first_lo", lo, 32'd15);
        chk("b2b_ready_gap", {31'd0, ready}, 32'd1);
        chk("b2b_stall_gap", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        chk("b2b_second_accepted", {31'd0, busy}, 32'd1);
        nb = 1;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            tick();
            if (busy === 1'b1) nb++;
        end
        chk("b2b_second_busy", nb, 32'd4);
        chk("b2b_second_lo", lo, 32'd24);
        chk("b2b_second_hi", hi, 32'd0);

        // Reset mid-DIV abandons the operation
        start = 1'b1; op = 2'd2; da = 32'd100; db = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        chk("rst_mid_dz", {31'd0, dz}, 32'd0);
        run_op(2'd1, 32'd3, 32'd4, nb);
        chk("post_rst_busy", nb, 32'd4);
        chk("post_rst_lo", lo, 32'd12);
        chk("post_rst_hi", hi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
